// File: rtl/fetch_pc_sequencer_if.sv
// fetch_pc_sequencer_if
// Groups the signals exchanged between fetch_pc_sequencer and fetch_unit /
// instruction queue. The sequencer connects through the master modport and
// the fetch side (or a testbench standing in for it) through the slave modport.
//
// Signals:
//   init_done    fetch -> seq : instruction memory ready
//   stall_in     fetch -> seq : global fetch stall
//   iq_full      fetch -> seq : instruction queue full
//   enq_accept   fetch -> seq : per-lane IQ enqueue this cycle
//   pc_out       seq -> fetch : registered fetch PC
//   fetch_hold   seq -> fetch : combinational imem stall request
//   fetch_squash seq -> fetch : combinational clear of imem fetch_reg valids
//   flush_out    seq -> fetch : registered one-cycle flush pulse
interface fetch_pc_sequencer_if #(
    parameter int ISSUE_WIDTH = 3
);
    logic                   init_done;
    logic                   stall_in;
    logic                   iq_full;
    logic [ISSUE_WIDTH-1:0] enq_accept;
    logic [31:0]            pc_out;
    logic                   fetch_hold;
    logic                   fetch_squash;
    logic                   flush_out;

    modport master (
        input  init_done, stall_in, iq_full, enq_accept,
        output pc_out, fetch_hold, fetch_squash, flush_out
    );

    modport slave (
        output init_done, stall_in, iq_full, enq_accept,
        input  pc_out, fetch_hold, fetch_squash, flush_out
    );
endinterface

// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer
// Owns the architectural fetch PC. Tracks the single bundle in flight between
// instruction memory and the instruction queue, replays it from the first
// unaccepted lane when the IQ takes only part of it, and redirects fetch on a
// backend request.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   fif (master)    fetch_unit / IQ handshake (see fetch_pc_sequencer_if)
//   redirect_valid  backend redirect request
//   redirect_pc     redirect target, low two bits dropped
//   halted          fetch has run off the end of the program
//   enq_err         sticky illegal enq_accept pattern flag
//   fetched_count   instructions enqueued (wraps)
//   replay_count    partial-accept replays (saturates)
//   redirect_count  redirects taken (saturates)
module fetch_pc_sequencer #(
    parameter int          ISSUE_WIDTH = 3,
    parameter int          NO_INSTR    = 33,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_pc_sequencer_if.master fif,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    output logic                 halted,
    output logic                 enq_err,
    output logic [31:0]          fetched_count,
    output logic [15:0]          replay_count,
    output logic [15:0]          redirect_count
);

    localparam int          CW       = $clog2(ISSUE_WIDTH + 1);
    localparam logic [31:0] END_ADDR = 32'(NO_INSTR * 4);

    typedef enum logic [1:0] {
        WAIT_INIT,
        FETCH,
        REDIRECT,
        HALT
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [31:0]            pc_q;
    logic [31:0]            bundle_pc;
    logic [CW-1:0]          bundle_n;
    logic                   bundle_vld;
    logic                   flush_q;

    logic [31:0]            words_left;
    logic [CW-1:0]          lane_n;
    logic [CW-1:0]          acc_k;
    logic [ISSUE_WIDTH-1:0] low_mask;
    logic                   pattern_bad;
    logic                   full_acc;
    logic                   partial;
    logic                   take_redirect;
    logic                   flush_redirect;
    logic                   replay;
    logic                   fire;
    logic                   hold_c;
    logic                   squash_c;

    // Number of lanes a bundle starting at the current PC may carry: a full
    // bundle, or whatever is left before the end of the program.
    always_comb begin
        words_left = '0;
        lane_n     = '0;
        if (pc_q < END_ADDR) begin
            words_left = (END_ADDR - pc_q) >> 2;
            if (words_left >= 32'(ISSUE_WIDTH)) begin
                lane_n = CW'(ISSUE_WIDTH);
            end else begin
                lane_n = words_left[CW-1:0];
            end
        end
    end

    // Count accepted lanes and build the only legal pattern for that count
    // (the lowest k lanes). Anything else, accepts with no bundle in flight,
    // or more lanes than the bundle holds is a protocol error; the popcount
    // is still used as the accept count either way.
    always_comb begin
        acc_k    = '0;
        low_mask = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            acc_k = acc_k + CW'(fif.enq_accept[i]);
        end
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            low_mask[i] = (i < int'(acc_k));
        end
        pattern_bad = (fif.enq_accept != low_mask) ||
                      ((acc_k != '0) && !bundle_vld) ||
                      (bundle_vld && (acc_k > bundle_n));
    end

    // Event qualifiers. A redirect outranks a replay, which outranks a fire.
    // A redirect in WAIT_INIT only moves the PC; flushing happens only when
    // leaving FETCH or HALT.
    assign full_acc       = bundle_vld && (acc_k == bundle_n);
    assign partial        = bundle_vld && (acc_k != '0) && (acc_k < bundle_n) &&
                            (state == FETCH);
    assign take_redirect  = redirect_valid && (state != REDIRECT);
    assign flush_redirect = redirect_valid && ((state == FETCH) || (state == HALT));
    assign replay         = partial && !take_redirect;
    assign fire           = (state == FETCH) && fif.init_done && !fif.stall_in &&
                            !fif.iq_full && !hold_c && (lane_n != '0) &&
                            !take_redirect;

    // State register for the fetch control FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and combinational outputs. Fetch is held in every state
    // except FETCH; inside FETCH only a partial accept holds and squashes the
    // imem so the partly enqueued bundle can be refetched from its first
    // unaccepted lane.
    always_comb begin
        state_next = state;
        hold_c     = 1'b1;
        squash_c   = 1'b0;
        halted     = 1'b0;
        case (state)
            WAIT_INIT: begin
                if (fif.init_done) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                hold_c   = partial;
                squash_c = partial;
                if (redirect_valid) begin
                    state_next = REDIRECT;
                end else if ((lane_n == '0) && !bundle_vld) begin
                    state_next = HALT;
                end
            end
            REDIRECT: begin
                state_next = WAIT_INIT;
            end
            HALT: begin
                halted = 1'b1;
                if (redirect_valid) begin
                    state_next = REDIRECT;
                end
            end
            default: begin
                state_next = WAIT_INIT;
            end
        endcase
    end

    // PC, in-flight bundle tracking, flush pulse, error flag and counters.
    // The PC update follows redirect > replay > fire; a bundle that is fully
    // accepted retires unless a new one is latched in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q           <= RESET_PC;
            bundle_pc      <= '0;
            bundle_n       <= '0;
            bundle_vld     <= 1'b0;
            flush_q        <= 1'b0;
            enq_err        <= 1'b0;
            fetched_count  <= '0;
            replay_count   <= '0;
            redirect_count <= '0;
        end else begin
            flush_q       <= flush_redirect;
            fetched_count <= fetched_count + 32'(acc_k);
            if (pattern_bad) begin
                enq_err <= 1'b1;
            end
            if (take_redirect) begin
                pc_q       <= redirect_pc & ~32'h3;
                bundle_vld <= 1'b0;
                if (redirect_count != 16'hFFFF) begin
                    redirect_count <= redirect_count + 16'd1;
                end
            end else if (replay) begin
                pc_q       <= bundle_pc + (32'(acc_k) << 2);
                bundle_vld <= 1'b0;
                if (replay_count != 16'hFFFF) begin
                    replay_count <= replay_count + 16'd1;
                end
            end else if (fire) begin
                bundle_pc  <= pc_q;
                bundle_n   <= lane_n;
                bundle_vld <= 1'b1;
                pc_q       <= pc_q + (32'(lane_n) << 2);
            end else if (full_acc) begin
                bundle_vld <= 1'b0;
            end
        end
    end

    assign fif.pc_out       = pc_q;
    assign fif.flush_out    = flush_q;
    assign fif.fetch_hold   = hold_c;
    assign fif.fetch_squash = squash_c;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// tb_fetch_pc_sequencer
// Directed testbench for fetch_pc_sequencer (ISSUE_WIDTH=3, NO_INSTR=33,
// RESET_PC=0). The bench plays the fetch_unit/IQ side through the slave
// modport of the interface. Inputs are driven and outputs sampled 1 ns after
// the rising edge; combinational outputs are sampled a further 1 ns after
// their inputs change.
module tb_fetch_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic        enq_err;
    logic [31:0] fetched_count;
    logic [15:0] replay_count;
    logic [15:0] redirect_count;
    int          total = 0;
    int          bad = 0;

    fetch_pc_sequencer_if #(.ISSUE_WIDTH(3)) fif ();

    fetch_pc_sequencer #(
        .ISSUE_WIDTH(3),
        .NO_INSTR   (33),
        .RESET_PC   (32'h0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fif           (fif),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halted        (halted),
        .enq_err       (enq_err),
        .fetched_count (fetched_count),
        .replay_count  (replay_count),
        .redirect_count(redirect_count)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Guards against the run never reaching its summary line.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run did not finish, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to 1 ns after the next rising edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reset, bring up, and run until the bundle at 0x18 is pending with
    // pc_out = 0x24 and fetched_count = 6. enq_accept is left at 3'b111.
    task automatic restart;
        rst_n          = 1'b0;
        fif.init_done  = 1'b0;
        fif.stall_in   = 1'b0;
        fif.iq_full    = 1'b0;
        fif.enq_accept = 3'b000;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        step;
        step;
        rst_n         = 1'b1;
        fif.init_done = 1'b1;
        step;
        step;
        fif.enq_accept = 3'b111;
        step;
        step;
    endtask

    task automatic test_reset;
        rst_n          = 1'b0;
        fif.init_done  = 1'b0;
        fif.stall_in   = 1'b0;
        fif.iq_full    = 1'b0;
        fif.enq_accept = 3'b000;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        step;
        step;
        step;
        total++; if (fif.pc_out !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc actual=%h required=%h", fif.pc_out, 32'h0); end
        total++; if (fif.fetch_hold !== 1'b1) begin bad++; $display("[TB] FAIL reset_hold actual=%b required=1", fif.fetch_hold); end
        total++; if (fif.fetch_squash !== 1'b0) begin bad++; $display("[TB] FAIL reset_squash actual=%b required=0", fif.fetch_squash); end
        total++; if (fif.flush_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_flush actual=%b required=0", fif.flush_out); end
        total++; if (halted !== 1'b0) begin bad++; $display("[TB] FAIL reset_halted actual=%b required=0", halted); end
        total++; if (enq_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err actual=%b required=0", enq_err); end
        total++; if (fetched_count !== 32'd0) begin bad++; $display("[TB] FAIL reset_fetched actual=%0d required=0", fetched_count); end
        total++; if (replay_count !== 16'd0 || redirect_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_counters actual=%0d/%0d required=0/0", replay_count, redirect_count); end
    endtask

    task automatic test_startup;
        rst_n = 1'b1;
        step;
        total++; if (fif.fetch_hold !== 1'b1) begin bad++; $display("[TB] FAIL wait_init_hold actual=%b required=1", fif.fetch_hold); end
        fif.init_done = 1'b1;
        step;
        #1;
        total++; if (fif.fetch_hold !== 1'b0) begin bad++; $display("[TB] FAIL fetch_hold_clear actual=%b required=0", fif.fetch_hold); end
        total++; if (fif.pc_out !== 32'h0) begin bad++; $display("[TB] FAIL start_pc0 actual=%h required=%h", fif.pc_out, 32'h0); end
        step;
        total++; if (fif.pc_out !== 32'hC || fetched_count !== 32'd0) begin bad++; $display("[TB] FAIL start_pc1 actual=%h/%0d required=0000000c/0", fif.pc_out, fetched_count); end
        fif.enq_accept = 3'b111;
        step;
        total++; if (fif.pc_out !== 32'h18 || fetched_count !== 32'd3) begin bad++; $display("[TB] FAIL start_pc2 actual=%h/%0d required=00000018/3", fif.pc_out, fetched_count); end
        step;
        total++; if (fif.pc_out !== 32'h24 || fetched_count !== 32'd6) begin bad++; $display("[TB] FAIL start_pc3 actual=%h/%0d required=00000024/6", fif.pc_out, fetched_count); end
    endtask

    task automatic test_stall;
        fif.stall_in   = 1'b1;
        fif.enq_accept = 3'b000;
        for (int i = 0; i < 4; i++) begin
            step;
            total++; if (fif.pc_out !== 32'h24) begin bad++; $display("[TB] FAIL stall_pc cycle=%0d actual=%h required=%h", i, fif.pc_out, 32'h24); end
        end
        total++; if (fetched_count !== 32'd6) begin bad++; $display("[TB] FAIL stall_fetched actual=%0d required=6", fetched_count); end
        fif.stall_in   = 1'b0;
        fif.enq_accept = 3'b111;
        step;
        total++; if (fif.pc_out !== 32'h30 || fetched_count !== 32'd9) begin bad++; $display("[TB] FAIL stall_release actual=%h/%0d required=00000030/9", fif.pc_out, fetched_count); end
    endtask

    task automatic test_partial;
        restart;
        fif.enq_accept = 3'b001;
        #1;
        total++; if (fif.fetch_hold !== 1'b1 || fif.fetch_squash !== 1'b1) begin bad++; $display("[TB] FAIL partial_hold_squash actual=%b%b required=11", fif.fetch_hold, fif.fetch_squash); end
        step;
        fif.enq_accept = 3'b000;
        total++; if (fif.pc_out !== 32'h1C) begin bad++; $display("[TB] FAIL partial_pc actual=%h required=%h", fif.pc_out, 32'h1C); end
        total++; if (replay_count !== 16'd1 || fetched_count !== 32'd7) begin bad++; $display("[TB] FAIL partial_counts actual=%0d/%0d required=1/7", replay_count, fetched_count); end
        #1;
        total++; if (fif.fetch_hold !== 1'b0 || fif.fetch_squash !== 1'b0) begin bad++; $display("[TB] FAIL partial_release actual=%b%b required=00", fif.fetch_hold, fif.fetch_squash); end
        step;
        total++; if (fif.pc_out !== 32'h28) begin bad++; $display("[TB] FAIL refetch_pc actual=%h required=%h", fif.pc_out, 32'h28); end
        fif.enq_accept = 3'b111;
        step;
        total++; if (fetched_count !== 32'd10 || fif.pc_out !== 32'h34 || enq_err !== 1'b0) begin bad++; $display("[TB] FAIL refetch_enq actual=%0d/%h/%b required=10/00000034/0", fetched_count, fif.pc_out, enq_err); end
    endtask

    task automatic test_redirect;
        restart;
        fif.enq_accept = 3'b011;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        step;
        total++; if (fif.flush_out !== 1'b1 || fif.pc_out !== 32'h40) begin bad++; $display("[TB] FAIL redir_flush_pc actual=%b/%h required=1/00000040", fif.flush_out, fif.pc_out); end
        total++; if (replay_count !== 16'd0 || redirect_count !== 16'd1 || fetched_count !== 32'd8) begin bad++; $display("[TB] FAIL redir_counts actual=%0d/%0d/%0d required=0/1/8", replay_count, redirect_count, fetched_count); end
        total++; if (fif.fetch_hold !== 1'b1) begin bad++; $display("[TB] FAIL redir_hold actual=%b required=1", fif.fetch_hold); end
        redirect_valid = 1'b0;
        fif.enq_accept = 3'b000;
        fif.init_done  = 1'b0;
        step;
        total++; if (fif.flush_out !== 1'b0 || fif.fetch_hold !== 1'b1 || fif.pc_out !== 32'h40) begin bad++; $display("[TB] FAIL redir_wait_init actual=%b/%b/%h required=0/1/00000040", fif.flush_out, fif.fetch_hold, fif.pc_out); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h50;
        step;
        total++; if (fif.pc_out !== 32'h50 || fif.flush_out !== 1'b0 || redirect_count !== 16'd2) begin bad++; $display("[TB] FAIL wait_init_redir actual=%h/%b/%0d required=00000050/0/2", fif.pc_out, fif.flush_out, redirect_count); end
        redirect_valid = 1'b0;
        fif.init_done  = 1'b1;
        step;
        #1;
        total++; if (fif.fetch_hold !== 1'b0) begin bad++; $display("[TB] FAIL redir_refetch_hold actual=%b required=0", fif.fetch_hold); end
        step;
        total++; if (fif.pc_out !== 32'h5C) begin bad++; $display("[TB] FAIL redir_refetch_pc actual=%h required=%h", fif.pc_out, 32'h5C); end
    endtask

    task automatic test_end_of_program;
        restart;
        fif.enq_accept = 3'b000;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h78;
        step;
        redirect_valid = 1'b0;
        step;
        step;
        total++; if (fif.pc_out !== 32'h78) begin bad++; $display("[TB] FAIL end_pc78 actual=%h required=%h", fif.pc_out, 32'h78); end
        step;
        total++; if (fif.pc_out !== 32'h84) begin bad++; $display("[TB] FAIL end_pc84 actual=%h required=%h", fif.pc_out, 32'h84); end
        fif.enq_accept = 3'b111;
        step;
        fif.enq_accept = 3'b000;
        total++; if (halted !== 1'b0 || fif.pc_out !== 32'h84) begin bad++; $display("[TB] FAIL end_drain actual=%b/%h required=0/00000084", halted, fif.pc_out); end
        step;
        total++; if (halted !== 1'b1 || fif.fetch_hold !== 1'b1) begin bad++; $display("[TB] FAIL end_halt actual=%b/%b required=1/1", halted, fif.fetch_hold); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8;
        step;
        redirect_valid = 1'b0;
        total++; if (fif.flush_out !== 1'b1 || halted !== 1'b0 || fif.pc_out !== 32'h8) begin bad++; $display("[TB] FAIL halt_redir actual=%b/%b/%h required=1/0/00000008", fif.flush_out, halted, fif.pc_out); end
        step;
        step;
        #1;
        total++; if (fif.fetch_hold !== 1'b0 || fif.pc_out !== 32'h8) begin bad++; $display("[TB] FAIL halt_refetch actual=%b/%h required=0/00000008", fif.fetch_hold, fif.pc_out); end
        step;
        total++; if (fif.pc_out !== 32'h14) begin bad++; $display("[TB] FAIL halt_refetch_pc actual=%h required=%h", fif.pc_out, 32'h14); end
        // Single-lane tail bundle at the last word of the program.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        step;
        redirect_valid = 1'b0;
        step;
        step;
        step;
        total++; if (fif.pc_out !== 32'h84) begin bad++; $display("[TB] FAIL tail_pc actual=%h required=%h", fif.pc_out, 32'h84); end
        fif.enq_accept = 3'b001;
        step;
        fif.enq_accept = 3'b000;
        step;
        total++; if (halted !== 1'b1 || enq_err !== 1'b0) begin bad++; $display("[TB] FAIL tail_halt actual=%b/%b required=1/0", halted, enq_err); end
    endtask

    task automatic test_protocol_reset;
        restart;
        fif.enq_accept = 3'b101;
        step;
        fif.enq_accept = 3'b000;
        total++; if (enq_err !== 1'b1) begin bad++; $display("[TB] FAIL err_set actual=%b required=1", enq_err); end
        step;
        total++; if (enq_err !== 1'b1) begin bad++; $display("[TB] FAIL err_sticky actual=%b required=1", enq_err); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h60;
        step;
        redirect_valid = 1'b0;
        total++; if (fif.flush_out !== 1'b1) begin bad++; $display("[TB] FAIL err_redir_flush actual=%b required=1", fif.flush_out); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (fif.flush_out !== 1'b0 || enq_err !== 1'b0 || fif.pc_out !== 32'h0) begin bad++; $display("[TB] FAIL abort_reset actual=%b/%b/%h required=0/0/00000000", fif.flush_out, enq_err, fif.pc_out); end
        total++; if (fif.fetch_hold !== 1'b1 || fif.fetch_squash !== 1'b0 || halted !== 1'b0) begin bad++; $display("[TB] FAIL abort_comb actual=%b/%b/%b required=1/0/0", fif.fetch_hold, fif.fetch_squash, halted); end
        total++; if (fetched_count !== 32'd0 || redirect_count !== 16'd0 || replay_count !== 16'd0) begin bad++; $display("[TB] FAIL abort_counters actual=%0d/%0d/%0d required=0/0/0", fetched_count, redirect_count, replay_count); end
        step;
        total++; if (fif.flush_out !== 1'b0) begin bad++; $display("[TB] FAIL abort_no_pulse actual=%b required=0", fif.flush_out); end
        rst_n = 1'b1;
        step;
    endtask

    initial begin
        test_reset;
        test_startup;
        test_stall;
        test_partial;
        test_redirect;
        test_end_of_program;
        test_protocol_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
